// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 write-only register controller.
// Synchronizes the host pins and commits 16-bit frames into config registers.
module spi_reg_ctrl #(
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  localparam int SW = $clog2(SYNC_STAGES + 2);
  localparam logic [SW-1:0] SETTLE = SW'(SYNC_STAGES + 1);
  localparam logic [6:0] NREG = 7'(NUM_REGS);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic sclk_hist;
  logic ncs_hist;

  logic sclk_s;
  logic copi_s;
  logic ncs_s;
  logic sclk_rise;
  logic ncs_rise;
  logic ncs_fall;

  logic [SW-1:0] settle;
  logic armed;

  state_t state;
  logic [15:0] sr;
  logic [4:0] cnt;
  logic [7:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_hist <= 1'b0;
      ncs_hist  <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      ncs_hist  <= ncs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign ncs_rise  = ncs_s & ~ncs_hist;
  assign ncs_fall  = ~ncs_s & ncs_hist;

  // A frame may only start once ncs has been seen high after the
  // synchronizers flushed their reset value; a frame cut by reset is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle <= '0;
      armed  <= 1'b0;
    end else if (settle != SETTLE) begin
      settle <= settle + 1'b1;
    end else if (ncs_s) begin
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ncs_fall && armed) begin
            sr    <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            state <= COMMIT;
          end else if (sclk_rise && !ncs_s) begin
            sr <= {sr[14:0], copi_s};
            if (cnt != 5'd17) cnt <= cnt + 5'd1;
          end
        end
        COMMIT: begin
          state <= IDLE;
          if (cnt == 5'd16) begin
            if (sr[15] && sr[14:8] < NREG) begin
              for (int i = 0; i < NUM_REGS; i++)
                if (sr[14:8] == 7'(i)) regs[i] <= sr[7:0];
              wr_strobe <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = regs[0];
  assign en_reg_out_15_8 = regs[1];
  assign en_reg_pwm_7_0  = regs[2];
  assign en_reg_pwm_15_8 = regs[3];
  assign pwm_duty_cycle  = regs[4];

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed SPI frames, frame-level model
// checked every cycle, plus literal spot checks.
module tb_spi_reg_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic sclk;
  logic copi;
  logic ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic wr_strobe;
  logic frame_err;

  spi_reg_ctrl dut (
    .clk(clk),
    .rst(rst),
    .sclk(sclk),
    .copi(copi),
    .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle),
    .wr_strobe(wr_strobe),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  bit chk_en = 0;

  logic [7:0] exp_reg [5];
  bit exp_wr;
  bit exp_err;
  int due = 0;
  int kind = 0;
  logic [2:0] pend_addr;
  logic [7:0] pend_data;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Frame-level model: outcome lands on the 4th clk edge after ncs rises.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) exp_reg[i] = 8'h00;
      exp_wr  = 0;
      exp_err = 0;
      due     = 0;
    end else begin
      exp_wr  = 0;
      exp_err = 0;
      if (due > 0) begin
        due--;
        if (due == 0) begin
          if (kind == 1) begin
            exp_reg[pend_addr] = pend_data;
            exp_wr = 1;
          end else if (kind == 2) begin
            exp_err = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_7_0", {24'h0, en_reg_out_7_0}, {24'h0, exp_reg[0]});
      chk("out_15_8", {24'h0, en_reg_out_15_8}, {24'h0, exp_reg[1]});
      chk("pwm_7_0", {24'h0, en_reg_pwm_7_0}, {24'h0, exp_reg[2]});
      chk("pwm_15_8", {24'h0, en_reg_pwm_15_8}, {24'h0, exp_reg[3]});
      chk("duty", {24'h0, pwm_duty_cycle}, {24'h0, exp_reg[4]});
      chk("wr_strobe", {31'h0, wr_strobe}, {31'h0, exp_wr});
      chk("frame_err", {31'h0, frame_err}, {31'h0, exp_err});
    end
  end

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) wr_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic schedule(input logic [31:0] bits, input int n);
    if (n != 16) begin
      kind = 2;
    end else if (bits[15] && bits[14:8] < 7'd5) begin
      kind = 1;
      pend_addr = bits[10:8];
      pend_data = bits[7:0];
    end else begin
      kind = 0;
    end
    due = 4;
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int hi,
                            input int lo);
    for (int i = hi; i >= lo; i--) begin
      sclk = 0;
      copi = bits[i];
      tick(5);
      sclk = 1;
      tick(5);
    end
    sclk = 0;
    tick(5);
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    ncs = 0;
    tick(5);
    if (n > 0) shift_bits(bits, n - 1, 0);
    ncs = 1;
    schedule(bits, n);
    tick(5);
  endtask

  int w0;
  int e0;

  initial begin
    rst = 0;
    sclk = 0;
    copi = 0;
    ncs = 1;
    #1 rst = 1;
    tick(3);
    rst = 0;
    tick(6);
    chk_en = 1;
    chk("rst_out_7_0", {24'h0, en_reg_out_7_0}, 32'h0);
    chk("rst_duty", {24'h0, pwm_duty_cycle}, 32'h0);
    chk("rst_wr", {31'h0, wr_strobe}, 32'h0);

    // First write, with edge-exact literal checks
    ncs = 0;
    tick(5);
    shift_bits(32'h80A5, 15, 0);
    ncs = 1;
    schedule(32'h80A5, 16);
    tick(3);
    chk("pre_commit", {24'h0, en_reg_out_7_0}, 32'h0);
    tick(1);
    chk("commit_4th", {24'h0, en_reg_out_7_0}, 32'hA5);
    chk("commit_wr", {31'h0, wr_strobe}, 32'h1);
    tick(1);
    chk("wr_one_cycle", {31'h0, wr_strobe}, 32'h0);
    tick(3);
    chk("t1_wr_cnt", wr_cnt, 1);
    chk("t1_out_15_8", {24'h0, en_reg_out_15_8}, 32'h0);

    // Back-to-back at minimum ncs-high gap
    w0 = wr_cnt;
    e0 = err_cnt;
    send(32'h84C0, 16);
    send(32'h8203, 16);
    tick(2);
    chk("b2b_duty", {24'h0, pwm_duty_cycle}, 32'hC0);
    chk("b2b_pwm_7_0", {24'h0, en_reg_pwm_7_0}, 32'h03);
    chk("b2b_wr", wr_cnt - w0, 2);
    chk("b2b_err", err_cnt - e0, 0);

    // Read and out-of-range write
    w0 = wr_cnt;
    e0 = err_cnt;
    send(32'h0412, 16);
    send(32'h8577, 16);
    tick(2);
    chk("rd_oor_wr", wr_cnt - w0, 0);
    chk("rd_oor_err", err_cnt - e0, 0);
    chk("rd_oor_out", {24'h0, en_reg_out_7_0}, 32'hA5);
    chk("rd_oor_duty", {24'h0, pwm_duty_cycle}, 32'hC0);

    // Bad bit counts
    w0 = wr_cnt;
    e0 = err_cnt;
    send(32'h0000_1234, 15);
    send(32'h0001_80FF, 17);
    send(32'h0, 0);
    tick(2);
    chk("bad_err", err_cnt - e0, 3);
    chk("bad_wr", wr_cnt - w0, 0);
    chk("bad_out", {24'h0, en_reg_out_15_8}, 32'h0);

    // Reset mid-frame, ncs still low at release
    w0 = wr_cnt;
    e0 = err_cnt;
    ncs = 0;
    tick(5);
    shift_bits(32'h81FF, 15, 8);
    rst = 1;
    tick(3);
    rst = 0;
    tick(5);
    shift_bits(32'h81FF, 7, 0);
    ncs = 1;
    tick(8);
    chk("mid_rst_out", {24'h0, en_reg_out_7_0}, 32'h0);
    chk("mid_rst_15_8", {24'h0, en_reg_out_15_8}, 32'h0);
    chk("mid_rst_wr", wr_cnt - w0, 0);
    chk("mid_rst_err", err_cnt - e0, 0);
    send(32'h81FF, 16);
    tick(2);
    chk("after_rst", {24'h0, en_reg_out_15_8}, 32'hFF);

    // Idle sclk toggles, then a valid frame
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      copi = i[0];
      sclk = 1;
      tick(5);
      sclk = 0;
      tick(5);
    end
    chk("idle_tog_wr", wr_cnt - w0, 0);
    send(32'h8355, 16);
    tick(2);
    chk("idle_pwm_15_8", {24'h0, en_reg_pwm_15_8}, 32'h55);
    chk("idle_wr", wr_cnt - w0, 1);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

SPI-mode-0 write-only register controller that configures the onboarding PWM/output datapath. It receives 16-bit command frames from an external host on three asynchronous pins, synchronizes them into the `clk` domain, and commits valid writes into five 8-bit configuration registers. It sits between the top-level `ui_in` pins and the PWM peripheral, which consumes the register outputs directly.

## Interface
- `NUM_REGS`, 5: number of implemented registers at addresses 0x00..NUM_REGS-1.
- `SYNC_STAGES`, 2: flip-flop stages per synchronizer, minimum 2.

- `clk`  in  1  system clock; all state in this domain.
- `rst`  in  1  asynchronous, active-high reset.
- `sclk`  in  1  SPI clock, asynchronous; idle low; data sampled on rising edge.
- `copi`  in  1  SPI data from host, asynchronous, MSB first.
- `ncs`  in  1  SPI chip select, active low, asynchronous.
- `en_reg_out_7_0`  out  8  register 0x00.
- `en_reg_out_15_8`  out  8  register 0x01.
- `en_reg_pwm_7_0`  out  8  register 0x02.
- `en_reg_pwm_15_8`  out  8  register 0x03.
- `pwm_duty_cycle`  out  8  register 0x04.
- `wr_strobe`  out  1  one-cycle pulse when a register is written.
- `frame_err`  out  1  one-cycle pulse when a frame ends with a bit count other than 16.

## Operation
- Synchronizers: one per input, `SYNC_STAGES` flops, plus one history flop per input for edge detection. On reset, `ncs` chain resets to 1; `sclk` and `copi` chains reset to 0. This guarantees no spurious edge after reset.
- Frame format, 16 bits, MSB first:
  - bit 15 is R/W: 1 = write, 0 = read. Reads are ignored and no data is driven.
  - bits 14:8 are the 7-bit address.
  - bits 7:0 are the data.
- FSM states:
  - IDLE: waits for a synchronized falling edge of `ncs`. On that edge it clears the 16-bit shift register and the 5-bit bit counter, then goes to SHIFT.
  - SHIFT: on each synchronized `sclk` rising edge while `ncs` is low, it shifts `copi` into the LSB and increments the bit counter. The counter saturates at 17, so any count above 16 reads as 17.
  - On a synchronized `ncs` rising edge, the block goes to COMMIT.
  - COMMIT (one cycle), then always returns to IDLE. Action depends on the bit counter:
    - Counter == 16, bit 15 == 1, address < `NUM_REGS`: write data to the addressed register and pulse `wr_strobe`.
    - Counter == 16 and (read, or address out of range): no write and no pulse.
    - Counter != 16, including 0: pulse `frame_err`; no write.
- `sclk` edges while in IDLE are ignored.
- `sclk` rising edge and `ncs` rising edge detected in the same cycle: the `ncs` edge wins and the `sclk` edge is discarded.
- Registers hold their values until the next valid write or reset. There is no read-back path.
- Reset values: all five registers 0x00, `wr_strobe` 0, `frame_err` 0, state IDLE, shift register 0, counter 0.
- Reset asserted mid-frame: the frame is abandoned. After release, the FSM stays in IDLE until a new `ncs` falling edge. If `ncs` is still low at release, the remaining bits are ignored and nothing commits.

## Timing
- Input-to-detect latency is `SYNC_STAGES`+1 `clk` edges.
- The commit is registered. Register outputs and `wr_strobe` change on `clk` edge `SYNC_STAGES`+2 after the `ncs` pin rises. With defaults, that is the 4th edge.
- `wr_strobe` and `frame_err` are each high for exactly one cycle per frame. They are mutually exclusive.
- Host requirements:
  - `sclk` high and low phases each ≥ `SYNC_STAGES`+2 `clk` periods.
  - `copi` stable from ≥ 1 `clk` period before to ≥ `SYNC_STAGES`+2 `clk` periods after each `sclk` rise.
  - `ncs` high between frames ≥ `SYNC_STAGES`+3 `clk` periods.
- Back-to-back frames that meet the `ncs`-high minimum must each commit independently; none may be lost.

## Test plan
- Reset, then frame 0x80A5: `en_reg_out_7_0`=0xA5 on the 4th `clk` edge after `ncs` rises; `wr_strobe` is one pulse; all other registers remain 0x00.
- Frames 0x84C0 then 0x8203, back-to-back at the minimum `ncs`-high gap: `pwm_duty_cycle`=0xC0 and `en_reg_pwm_7_0`=0x03; two `wr_strobe` pulses; 0 `frame_err` pulses.
- Read frame 0x0412 and out-of-range write 0x8577: all registers unchanged; no `wr_strobe` and no `frame_err`.
- 15-bit frame, 17-bit frame and 0-bit frame (`ncs` low then high with no `sclk`): one `frame_err` pulse each; no register change.
- Assert `rst` after 8 bits of 0x81FF, release with `ncs` still low, finish the frame: all registers 0x00 and no strobe. The next frame 0x81FF then sets `en_reg_out_15_8`=0xFF.
- `sclk` toggled with `ncs` high, followed by valid frame 0x8355: idle toggles have no effect; `en_reg_pwm_15_8`=0x55.
